// File: rtl/cr_pipe_hs_if.sv
// Valid/ready/data stream bundle used on both sides of cr_pipe_hs.
// The master drives Valid and Data, and the slave drives Ready.
interface cr_pipe_hs_if #(
  parameter int unsigned pWidth = 10
) ();
  logic              Valid;
  logic              Ready;
  logic [pWidth-1:0] Data;

  modport master (output Valid, output Data, input Ready);
  modport slave  (input Valid, input Data, output Ready);
endinterface

// File: rtl/cr_pipe_hs.sv
// Elastic pipeline: a chain of two-entry skid buffers carrying data forward and ready backward.
// S.Ready is registered in every stage, so no combinational path runs from M.Ready to S.Ready.
module cr_pipe_hs #(
  parameter int unsigned pWidth  = 10,
  parameter int unsigned pStages = 2,
  parameter int unsigned pCntW   = 4
) (
  input  logic             Clk,
  input  logic             Rst_n,
  cr_pipe_hs_if.slave      S,
  cr_pipe_hs_if.master     M,
  output logic [pCntW-1:0] Count
);

  if (pStages == 0) begin : g_pass
    assign M.Valid = S.Valid;
    assign M.Data  = S.Data;
    assign S.Ready = M.Ready;
    assign Count   = '0;
  end else begin : g_pipe
    localparam logic [pCntW-1:0] CntOne = pCntW'(1);

    // Index k is the input side of stage k; index pStages is the M side.
    logic              vld [pStages+1];
    logic              rdy [pStages+1];
    logic [pWidth-1:0] dat [pStages+1];

    assign vld[0]       = S.Valid;
    assign dat[0]       = S.Data;
    assign S.Ready      = rdy[0];
    assign rdy[pStages] = M.Ready;
    assign M.Valid      = vld[pStages];
    assign M.Data       = dat[pStages];

    for (genvar k = 0; k < pStages; k++) begin : g_stage
      logic              main_v_q, main_v_d;
      logic              skid_v_q, skid_v_d;
      logic              rdy_q, rdy_d;
      logic [pWidth-1:0] main_dat_q, main_dat_d;
      logic [pWidth-1:0] skid_dat_q, skid_dat_d;
      logic              acc, pop;

      assign acc = vld[k] & rdy_q;
      assign pop = main_v_q & rdy[k+1];

      always_comb begin
        main_v_d   = main_v_q;
        main_dat_d = main_dat_q;
        skid_v_d   = skid_v_q;
        skid_dat_d = skid_dat_q;
        if (!main_v_q || pop) begin
          // rdy_q is low whenever skid is occupied, so acc cannot coincide with a skid refill.
          if (skid_v_q) begin
            main_v_d   = 1'b1;
            main_dat_d = skid_dat_q;
            skid_v_d   = 1'b0;
          end else if (acc) begin
            main_v_d   = 1'b1;
            main_dat_d = dat[k];
          end else begin
            main_v_d   = 1'b0;
          end
        end else if (acc) begin
          skid_v_d   = 1'b1;
          skid_dat_d = dat[k];
        end
        rdy_d = !skid_v_d;
      end

      always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
          main_v_q   <= 1'b0;
          skid_v_q   <= 1'b0;
          rdy_q      <= 1'b0;
          main_dat_q <= '0;
          skid_dat_q <= '0;
        end else begin
          main_v_q   <= main_v_d;
          skid_v_q   <= skid_v_d;
          rdy_q      <= rdy_d;
          main_dat_q <= main_dat_d;
          skid_dat_q <= skid_dat_d;
        end
      end

      assign rdy[k]   = rdy_q;
      assign vld[k+1] = main_v_q;
      assign dat[k+1] = main_dat_q;
    end

    logic             s_xfer, m_xfer;
    logic [pCntW-1:0] count_q, count_d;

    assign s_xfer = vld[0] & rdy[0];
    assign m_xfer = vld[pStages] & rdy[pStages];

    always_comb begin
      count_d = count_q;
      if (s_xfer && !m_xfer) begin
        count_d = count_q + CntOne;
      end else if (!s_xfer && m_xfer) begin
        count_d = count_q - CntOne;
      end
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
      if (!Rst_n) begin
        count_q <= '0;
      end else begin
        count_q <= count_d;
      end
    end

    assign Count = count_q;
  end

endmodule

// File: tb/tb_cr_pipe_hs.sv
// Bench for cr_pipe_hs with 8-bit data and 3 stages: vector table, stream, random scoreboard
// and mid-stream reset.
module tb_cr_pipe_hs;

  localparam int unsigned W      = 8;
  localparam int unsigned NStg   = 3;
  localparam int unsigned CntW   = 4;
  localparam int unsigned NBeats = 1000;

  logic            Clk;
  logic            Rst_n;
  logic [CntW-1:0] Count;

  cr_pipe_hs_if #(.pWidth(W)) s_bus ();
  cr_pipe_hs_if #(.pWidth(W)) m_bus ();

  cr_pipe_hs #(
    .pWidth (W),
    .pStages(NStg),
    .pCntW  (CntW)
  ) dut (
    .Clk  (Clk),
    .Rst_n(Rst_n),
    .S    (s_bus),
    .M    (m_bus),
    .Count(Count)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  int unsigned total = 0;
  int unsigned bad   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  typedef struct {
    logic        s_valid;
    logic [7:0]  s_data;
    logic        m_ready;
    logic        exp_s_ready;
    logic        exp_m_valid;
    logic [7:0]  exp_m_data;
    int unsigned exp_count;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic sv, input logic [7:0] sd, input logic mr, input logic esr,
                     input logic emv, input logic [7:0] emd, input int unsigned ec);
    vec_t v;
    v.s_valid     = sv;
    v.s_data      = sd;
    v.m_ready     = mr;
    v.exp_s_ready = esr;
    v.exp_m_valid = emv;
    v.exp_m_data  = emd;
    v.exp_count   = ec;
    vecs.push_back(v);
  endtask

  initial begin
    #900_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    logic [7:0]  q[$];
    logic [7:0]  exp_d;
    logic [7:0]  hold_d;
    logic        hold_v;
    int unsigned sent, got, cyc, acc, del, seen;

    Rst_n        = 1'b0;
    s_bus.Valid  = 1'b0;
    s_bus.Data   = '0;
    m_bus.Ready  = 1'b0;

    // Reset release: S.Ready stays low until the first edge after release.
    repeat (2) step();
    check("rst_sready", 32'(s_bus.Ready), 0);
    check("rst_mvalid", 32'(m_bus.Valid), 0);
    check("rst_mdata",  32'(m_bus.Data),  0);
    check("rst_count",  32'(Count),       0);
    #3;
    Rst_n = 1'b1;
    #1;
    check("rel_sready_pre", 32'(s_bus.Ready), 0);
    check("rel_mvalid_pre", 32'(m_bus.Valid), 0);
    step();
    check("rel_sready_post", 32'(s_bus.Ready), 1);
    check("rel_mvalid_post", 32'(m_bus.Valid), 0);
    check("rel_count_post",  32'(Count),       0);

    // Single beat, then fill with M.Ready low, then drain.
    add(1, 8'hA5, 1, 1, 0, 8'h00, 1);
    add(0, 8'hFF, 1, 1, 0, 8'h00, 1);
    add(0, 8'h3C, 1, 1, 1, 8'hA5, 1);
    add(0, 8'h00, 1, 1, 0, 8'h00, 0);
    add(1, 8'h10, 0, 1, 0, 8'h00, 1);
    add(1, 8'h11, 0, 1, 0, 8'h00, 2);
    add(1, 8'h12, 0, 1, 1, 8'h10, 3);
    add(1, 8'h13, 0, 1, 1, 8'h10, 4);
    add(1, 8'h14, 0, 1, 1, 8'h10, 5);
    add(1, 8'h15, 0, 0, 1, 8'h10, 6);
    add(1, 8'h16, 0, 0, 1, 8'h10, 6);
    add(1, 8'h17, 0, 0, 1, 8'h10, 6);
    add(0, 8'hEE, 1, 0, 1, 8'h11, 5);
    add(0, 8'hEE, 1, 0, 1, 8'h12, 4);
    add(0, 8'hEE, 1, 1, 1, 8'h13, 3);
    add(0, 8'hEE, 1, 1, 1, 8'h14, 2);
    add(0, 8'hEE, 1, 1, 1, 8'h15, 1);
    add(0, 8'hEE, 1, 1, 0, 8'h00, 0);

    foreach (vecs[i]) begin
      s_bus.Valid = vecs[i].s_valid;
      s_bus.Data  = vecs[i].s_data;
      m_bus.Ready = vecs[i].m_ready;
      step();
      check($sformatf("vec%0d_sready", i), 32'(s_bus.Ready), 32'(vecs[i].exp_s_ready));
      check($sformatf("vec%0d_mvalid", i), 32'(m_bus.Valid), 32'(vecs[i].exp_m_valid));
      check($sformatf("vec%0d_count", i),  32'(Count),       vecs[i].exp_count);
      if (vecs[i].exp_m_valid)
        check($sformatf("vec%0d_mdata", i), 32'(m_bus.Data), 32'(vecs[i].exp_m_data));
    end

    // Back-to-back stream: beat j is accepted at edge j, visible after edge j+2, gone at j+3.
    for (int n = 0; n < 20; n++) begin
      s_bus.Valid = (n < 16);
      s_bus.Data  = 8'(n);
      m_bus.Ready = 1'b1;
      step();
      acc = (n + 1 < 16) ? n + 1 : 16;
      del = (n >= 3) ? ((n - 2 < 16) ? n - 2 : 16) : 0;
      check("stream_count", 32'(Count), acc - del);
      check("stream_mvalid", 32'(m_bus.Valid), 32'(n >= 2 && n <= 17));
      if (n >= 2 && n <= 17) check("stream_mdata", 32'(m_bus.Data), 32'(n - 2));
      if (n < 16) check("stream_sready", 32'(s_bus.Ready), 1);
    end

    // Random valid/ready against a FIFO scoreboard.
    sent   = 0;
    got    = 0;
    cyc    = 0;
    hold_v = 1'b0;
    hold_d = '0;
    while (got < NBeats && cyc < 20000) begin
      if (hold_v) begin
        check("rand_hold_valid", 32'(m_bus.Valid), 1);
        check("rand_hold_data",  32'(m_bus.Data),  32'(hold_d));
      end
      s_bus.Valid = (sent < NBeats) && ($urandom_range(1, 0) == 1);
      s_bus.Data  = 8'($urandom);
      m_bus.Ready = ($urandom_range(1, 0) == 1);
      #1;
      if (m_bus.Valid && m_bus.Ready) begin
        if (q.size() == 0) begin
          check("rand_spurious_beat", 32'(m_bus.Data), 32'hDEAD);
        end else begin
          exp_d = q.pop_front();
          check("rand_data", 32'(m_bus.Data), 32'(exp_d));
        end
        got++;
      end
      if (s_bus.Valid && s_bus.Ready) begin
        q.push_back(s_bus.Data);
        sent++;
      end
      hold_v = m_bus.Valid && !m_bus.Ready;
      hold_d = m_bus.Data;
      step();
      cyc++;
      check("rand_count", 32'(Count), q.size());
      check("rand_count_max", 32'(Count <= 6), 1);
    end
    check("rand_delivered", got, NBeats);
    s_bus.Valid = 1'b0;
    m_bus.Ready = 1'b1;
    repeat (8) step();
    check("rand_drained_count", 32'(Count), 0);

    // Reset with four beats held: everything is discarded at once.
    for (int i = 0; i < 4; i++) begin
      s_bus.Valid = 1'b1;
      s_bus.Data  = 8'(8'h20 + i);
      m_bus.Ready = 1'b0;
      step();
    end
    s_bus.Valid = 1'b0;
    check("mid_count_before", 32'(Count), 4);
    check("mid_mvalid_before", 32'(m_bus.Valid), 1);
    #2;
    Rst_n = 1'b0;
    #1;
    check("mid_rst_mvalid", 32'(m_bus.Valid), 0);
    check("mid_rst_count",  32'(Count),       0);
    check("mid_rst_sready", 32'(s_bus.Ready), 0);
    #2;
    Rst_n = 1'b1;
    step();
    check("mid_rel_sready", 32'(s_bus.Ready), 1);
    s_bus.Valid = 1'b1;
    s_bus.Data  = 8'h5A;
    m_bus.Ready = 1'b1;
    step();
    s_bus.Valid = 1'b0;
    s_bus.Data  = 8'hC3;
    seen = 0;
    for (int j = 0; j < 8; j++) begin
      step();
      check("mid_new_mvalid", 32'(m_bus.Valid), 32'(j == 1));
      if (m_bus.Valid) begin
        seen++;
        check("mid_new_mdata", 32'(m_bus.Data), 32'h5A);
      end
    end
    check("mid_new_beats", seen, 1);
    check("mid_final_count", 32'(Count), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
